// File: rtl/run_controller.sv
// run_controller
// Host-side sequencer for the 9-bit RISC CPU top level. It performs these steps
// for each run:
//   1. Preload data memory from a write stream.
//   2. Hold the CPU in start for START_CYCLES cycles.
//   3. Release the CPU and count cycles until cpu_done, or until TIMEOUT.
//   4. Freeze the CPU again and stream a window of data memory out as results.
//
// Ports
//   clk          clock, all state on rising edge
//   reset        asynchronous active-low reset
//   go           begin a run (honoured only in IDLE or DONE)
//   dump_base    first dump address, latched on accepted go
//   dump_len     dump word count 0..256, latched on accepted go
//   ld_valid/ld_ready/ld_addr/ld_data/ld_last   preload write stream
//   dm_own       1 = controller owns the data-memory port
//   dm_wr_en/dm_addr/dm_wr_data                 data-memory write/address
//   dm_rd_data   combinational read data for dm_addr
//   cpu_start    CPU start/reset input (1 = held)
//   cpu_done     CPU done flag
//   res_valid/res_ready/res_addr/res_data       result dump stream
//   busy         1 in LOAD/START/RUN/DUMP
//   finished     1 in DONE
//   timed_out    last run hit TIMEOUT
//   cycle_count  RUN cycles of last/current run (saturating)
module run_controller #(
  parameter int unsigned START_CYCLES = 2,
  parameter logic [31:0] TIMEOUT      = 32'd65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [7:0]  dump_base,
  input  logic [8:0]  dump_len,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [7:0]  ld_addr,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        dm_own,
  output logic        dm_wr_en,
  output logic [7:0]  dm_addr,
  output logic [7:0]  dm_wr_data,
  input  logic [7:0]  dm_rd_data,
  output logic        cpu_start,
  input  logic        cpu_done,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_addr,
  output logic [7:0]  res_data,
  output logic        busy,
  output logic        finished,
  output logic        timed_out,
  output logic [31:0] cycle_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DUMP  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [31:0] START_LAST = 32'(START_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  base_q, base_d;
  logic [8:0]  len_q, len_d;
  logic [8:0]  idx_q, idx_d;
  logic [31:0] scnt_q, scnt_d;
  logic [31:0] cyc_q, cyc_d;
  logic        to_q, to_d;

  logic [7:0]  dump_addr;
  logic        in_load, in_start, in_run, in_dump, in_done;

  assign in_load  = (state_q == S_LOAD);
  assign in_start = (state_q == S_START);
  assign in_run   = (state_q == S_RUN);
  assign in_dump  = (state_q == S_DUMP);
  assign in_done  = (state_q == S_DONE);

  // Address arithmetic is 8-bit, so a window crossing 0xff wraps naturally.
  assign dump_addr = base_q + idx_q[7:0];

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    idx_d   = idx_q;
    scnt_d  = scnt_q;
    cyc_d   = cyc_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          base_d  = dump_base;
          len_d   = dump_len;
          to_d    = 1'b0;
          cyc_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // ld_ready is constantly high here, so ld_valid alone means accepted.
        if (ld_valid && ld_last) begin
          scnt_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (scnt_q == START_LAST) begin
          state_d = S_RUN;
        end else begin
          scnt_d = scnt_q + 32'd1;
        end
      end
      S_RUN: begin
        // cpu_done wins over the timeout check in the same cycle.
        if (cpu_done) begin
          idx_d   = '0;
          state_d = S_DUMP;
        end else if (cyc_q == TIMEOUT) begin
          to_d    = 1'b1;
          idx_d   = '0;
          state_d = S_DUMP;
        end else if (cyc_q != 32'hffff_ffff) begin
          cyc_d = cyc_q + 32'd1;
        end
      end
      S_DUMP: begin
        if (len_q == 9'd0) begin
          state_d = S_DONE;
        end else if (res_ready) begin
          if (idx_q == len_q - 9'd1) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 9'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      scnt_q  <= '0;
      cyc_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      scnt_q  <= scnt_d;
      cyc_q   <= cyc_d;
      to_q    <= to_d;
    end
  end

  // Dump window settings are plain data; they are always rewritten on go
  // before use, so they carry no reset.
  always_ff @(posedge clk) begin
    base_q <= base_d;
    len_q  <= len_d;
  end

  assign ld_ready    = in_load;
  assign dm_own      = in_load | in_start | in_dump;
  assign dm_wr_en    = in_load & ld_valid;
  assign dm_addr     = in_load ? ld_addr : (in_dump ? dump_addr : 8'h00);
  assign dm_wr_data  = in_load ? ld_data : 8'h00;
  // The CPU only runs in RUN; every other state keeps it held.
  assign cpu_start   = ~in_run;
  assign res_valid   = in_dump & (len_q != 9'd0);
  assign res_addr    = in_dump ? dump_addr : 8'h00;
  assign res_data    = res_valid ? dm_rd_data : 8'h00;
  assign busy        = in_load | in_start | in_run | in_dump;
  assign finished    = in_done;
  assign timed_out   = to_q;
  assign cycle_count = cyc_q;

endmodule

// File: tb/tb_run_controller.sv
module tb_run_controller;
  localparam int unsigned START_N = 2;
  localparam logic [31:0] TO_N    = 32'd50;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic [7:0]  dump_base;
  logic [8:0]  dump_len;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_addr;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        dm_own;
  logic        dm_wr_en;
  logic [7:0]  dm_addr;
  logic [7:0]  dm_wr_data;
  logic [7:0]  dm_rd_data;
  logic        cpu_start;
  logic        cpu_done;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_addr;
  logic [7:0]  res_data;
  logic        busy;
  logic        finished;
  logic        timed_out;
  logic [31:0] cycle_count;

  run_controller #(.START_CYCLES(START_N), .TIMEOUT(TO_N)) dut (
    .clk(clk), .reset(reset), .go(go), .dump_base(dump_base), .dump_len(dump_len),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_last(ld_last), .dm_own(dm_own), .dm_wr_en(dm_wr_en), .dm_addr(dm_addr),
    .dm_wr_data(dm_wr_data), .dm_rd_data(dm_rd_data), .cpu_start(cpu_start),
    .cpu_done(cpu_done), .res_valid(res_valid), .res_ready(res_ready),
    .res_addr(res_addr), .res_data(res_data), .busy(busy), .finished(finished),
    .timed_out(timed_out), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } pair_t;
  pair_t wq[$];
  pair_t dq[$];

  // Data memory model (written only by DUT writes) and its reference copy.
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  assign dm_rd_data = mem[dm_addr];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5a;
    forever begin
      @(posedge clk);
      if (reset && dm_own && dm_wr_en) mem[dm_addr] = dm_wr_data;
    end
  end

  // CPU model: rc counts RUN cycles including the current one.
  int  rc = 0;
  int  done_after = 1000;
  logic done_en = 1'b0;
  logic force_done = 1'b0;
  assign cpu_done = force_done | (done_en & ~cpu_start & (rc > done_after));

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cpu_start) rc = 0;
      else rc = rc + 1;
    end
  end

  // Result consumer: always ready, or 1,0,1,0... starting with each dump.
  logic rr_toggle = 1'b0;
  logic ph = 1'b0;
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (res_valid) begin
        res_ready = ~rr_toggle | ~ph;
        ph = ~ph;
      end else begin
        ph = 1'b0;
        res_ready = 1'b1;
      end
    end
  end

  // Monitor: compares every write and every presented result with the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (dm_wr_en) begin
          if (wq.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_write addr=%0h data=%0h", dm_addr, dm_wr_data);
          end else begin
            chk("wr_addr", 32'(dm_addr), 32'(wq[0].a));
            chk("wr_data", 32'(dm_wr_data), 32'(wq[0].d));
            chk("wr_own", 32'(dm_own), 32'd1);
            void'(wq.pop_front());
          end
        end
        if (res_valid) begin
          if (dq.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_res_valid addr=%0h data=%0h", res_addr, res_data);
          end else begin
            chk("res_addr", 32'(res_addr), 32'(dq[0].a));
            chk("res_data", 32'(res_data), 32'(dq[0].d));
            if (res_ready) begin
              void'(dq.pop_front());
              hs_cnt++;
            end
          end
        end
      end
    end
  end

  task automatic start_run(input logic [7:0] b, input logic [8:0] l);
    @(posedge clk); #1;
    go = 1'b1; dump_base = b; dump_len = l;
    @(posedge clk); #1;
    go = 1'b0;
    chk("load_ready", 32'(ld_ready), 32'd1);
    chk("load_busy", 32'(busy), 32'd1);
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] d, input logic last);
    pair_t p;
    p.a = a; p.d = d;
    ref_mem[a] = d;
    wq.push_back(p);
    ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic expect_dump(input logic [7:0] b, input int l);
    pair_t p;
    for (int i = 0; i < l; i++) begin
      p.a = b + 8'(i);
      p.d = ref_mem[p.a];
      dq.push_back(p);
    end
  endtask

  task automatic wait_release(input string name);
    int n = 0;
    forever begin
      @(negedge clk);
      if (!cpu_start || n > 20) break;
      n++;
    end
    chk(name, 32'(n), 32'(START_N));
  endtask

  task automatic wait_finished(input string name);
    int k = 0;
    while (!finished && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(finished), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5a;
    reset = 1'b0; go = 1'b0; dump_base = 8'h00; dump_len = 9'd0;
    ld_valid = 1'b0; ld_addr = 8'h00; ld_data = 8'h00; ld_last = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_cpu_start", 32'(cpu_start), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_finished", 32'(finished), 32'd0);
    chk("rst_dm_own", 32'(dm_own), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_cycle_count", cycle_count, 32'd0);
    chk("rst_timed_out", 32'(timed_out), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Run 1: four-beat preload with a gap, done after 20 cycles, stalled dump
    done_en = 1'b1; done_after = 20; rr_toggle = 1'b1; hs_cnt = 0;
    start_run(8'h01, 9'd4);
    beat(8'h01, 8'h03, 1'b0);
    beat(8'h02, 8'hff, 1'b0);
    @(posedge clk); #1;
    beat(8'h03, 8'hff, 1'b0);
    beat(8'h04, 8'hfb, 1'b1);
    chk("r1_writes_left", 32'(wq.size()), 32'd0);
    expect_dump(8'h01, 4);
    wait_release("r1_start_cycles");
    @(posedge clk); #1;
    go = 1'b1; dump_base = 8'h80; dump_len = 9'd9;
    @(posedge clk); #1;
    go = 1'b0;
    chk("r1_go_ignored_busy", 32'(busy), 32'd1);
    chk("r1_go_ignored_cpu", 32'(cpu_start), 32'd0);
    wait_finished("r1_finished");
    chk("r1_cycle_count", cycle_count, 32'd20);
    chk("r1_timed_out", 32'(timed_out), 32'd0);
    chk("r1_busy", 32'(busy), 32'd0);
    chk("r1_cpu_held", 32'(cpu_start), 32'd1);
    chk("r1_handshakes", 32'(hs_cnt), 32'd4);
    chk("r1_dump_left", 32'(dq.size()), 32'd0);

    // Run 2: timeout with wrapping dump window
    done_en = 1'b0; rr_toggle = 1'b0;
    start_run(8'hff, 9'd3);
    beat(8'h00, 8'h11, 1'b1);
    expect_dump(8'hff, 3);
    wait_release("r2_start_cycles");
    wait_finished("r2_finished");
    chk("r2_timed_out", 32'(timed_out), 32'd1);
    chk("r2_cycle_count", cycle_count, 32'd50);
    chk("r2_dump_left", 32'(dq.size()), 32'd0);

    // Run 3: next go clears timeout; dump_len = 0
    done_en = 1'b1; done_after = 5;
    start_run(8'h10, 9'd0);
    chk("r3_timed_out_cleared", 32'(timed_out), 32'd0);
    chk("r3_cycle_cleared", cycle_count, 32'd0);
    beat(8'h10, 8'h42, 1'b1);
    wait_release("r3_start_cycles");
    begin
      int k = 0;
      while (!cpu_start && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    chk("r3_dump_not_done", 32'(finished), 32'd0);
    @(negedge clk);
    chk("r3_done_next_cycle", 32'(finished), 32'd1);
    chk("r3_cycle_count", cycle_count, 32'd5);

    // Run 4: cpu_done high throughout START is ignored
    force_done = 1'b1; done_en = 1'b0;
    start_run(8'h20, 9'd2);
    beat(8'h20, 8'haa, 1'b0);
    beat(8'h21, 8'hbb, 1'b1);
    expect_dump(8'h20, 2);
    wait_release("r4_start_cycles");
    wait_finished("r4_finished");
    force_done = 1'b0;
    chk("r4_cycle_count", cycle_count, 32'd0);
    chk("r4_dump_left", 32'(dq.size()), 32'd0);

    // Run 5: asynchronous reset during RUN, then a clean restart
    start_run(8'h00, 9'd1);
    beat(8'h05, 8'h77, 1'b1);
    wait_release("r5_start_cycles");
    repeat (10) @(negedge clk);
    chk("r5_cycle_before_reset", cycle_count, 32'd10);
    #2;
    reset = 1'b0;
    #1;
    chk("r5_rst_cpu_start", 32'(cpu_start), 32'd1);
    chk("r5_rst_busy", 32'(busy), 32'd0);
    chk("r5_rst_cycle_count", cycle_count, 32'd0);
    chk("r5_rst_dm_own", 32'(dm_own), 32'd0);
    chk("r5_rst_res_addr", 32'(res_addr), 32'd0);
    chk("r5_rst_finished", 32'(finished), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    done_en = 1'b1; done_after = 3;
    start_run(8'h05, 9'd1);
    beat(8'h06, 8'h66, 1'b1);
    expect_dump(8'h05, 1);
    wait_release("r6_start_cycles");
    wait_finished("r6_finished");
    chk("r6_cycle_count", cycle_count, 32'd3);
    chk("r6_dump_left", 32'(dq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
